async_fifo_read_drainer: RTL

//  Read-side consumer of the async FIFO read channel. Drives read_fifo_pop and

---
 rtl/async_fifo_read_drainer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/async_fifo_read_drainer.sv
// Read-side drainer for an async FIFO read port.
// Pops the FIFO while room exists in a small in-order buffer, captures read_data
// READ_LATENCY cycles after each pop, and presents the words on a valid/ready
// stream. The buffer is sized so that words already in flight always have room.
module async_fifo_read_drainer #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int READ_LATENCY    = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       read_clk,
  input  logic                       read_reset,
  input  logic                       enable,
  output logic                       read_fifo_pop,
  input  logic                       read_fifo_empty,
  input  logic [FIFO_DATA_WIDTH-1:0] read_data,
  output logic                       m_valid,
  output logic [FIFO_DATA_WIDTH-1:0] m_data,
  input  logic                       m_ready,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       pop_count
);

  localparam int BUF_DEPTH = READ_LATENCY + 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [READ_LATENCY-1:0]    pipe_q, pipe_d;
  logic [FIFO_DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [FIFO_DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]           head_q, head_d;
  logic [PTR_W-1:0]           tail_q, tail_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [CNT_WIDTH-1:0]       pop_count_q, pop_count_d;

  logic [OCC_W-1:0]           inflight;
  logic [OCC_W:0]             load;
  logic                       capture;
  logic                       xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign m_valid   = (occ_q != '0);
  assign m_data    = mem_q[head_q];
  assign busy      = (state_q != IDLE);
  assign pop_count = pop_count_q;
  assign capture   = pipe_q[READ_LATENCY-1];
  assign xfer      = m_valid & m_ready;

  // Count outstanding pops and decide whether another one fits in the buffer.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OCC_W'(pipe_q[i]);
    end
    load          = {1'b0, occ_q} + {1'b0, inflight};
    read_fifo_pop = (state_q == RUN) && !read_fifo_empty && (load < (OCC_W + 1)'(BUF_DEPTH));
  end

  // Next-state logic: RUN while enabled, then DRAIN until nothing is outstanding.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN:   if (inflight == '0 && occ_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: pop-flag shift, buffer write/read pointers, occupancy, counter.
  always_comb begin
    pipe_d[0] = read_fifo_pop;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    pop_count_d = pop_count_q + CNT_WIDTH'(read_fifo_pop);
    if (capture) begin
      mem_d[tail_q] = read_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (xfer) begin
      head_d = ptr_inc(head_q);
    end
    unique case ({capture, xfer})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State register.
  always_ff @(posedge read_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (read_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Datapath registers; reset discards anything buffered or in flight.
  always_ff @(posedge read_clk) begin
    if (read_reset) begin
      pipe_q      <= '0;
      // NOTE: the buffer is a small register array and is cleared so m_data reads 0 after reset.
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      pop_count_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      mem_q       <= mem_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      pop_count_q <= pop_count_d;
    end
  end

  // Overflow guard: a capture into a full buffer with no transfer would lose a word.
  always_ff @(posedge read_clk) begin
    if (!read_reset) begin
      overflow_chk: assert (!(capture && !xfer && occ_q == OCC_W'(BUF_DEPTH)));
    end
  end

endmodule
